// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Shared ALU control codes, slice op encodings and sequencer states.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUM = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_alu_slice.sv
// +----------------------------------------------------------------------+
// | serial_alu_slice                                                     |
// | Combinational 1-bit ALU slice: AND / OR / SUM / LESS pass-through.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_alu_slice
    import alu_pkg::*;
(
    input  logic       in1,
    input  logic       in2,
    input  logic       carryIn,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       less,
    input  logic [1:0] op,
    output logic       result,
    output logic       carryOut
);

    logic a_eff;
    logic b_eff;
    logic sum;

    assign a_eff    = ainvert ? ~in1 : in1;
    assign b_eff    = binvert ? ~in2 : in2;
    assign sum      = a_eff ^ b_eff ^ carryIn;
    assign carryOut = (a_eff & b_eff) | (a_eff & carryIn) | (b_eff & carryIn);

    always_comb begin
        result = 1'b0;
        case (op)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_SUM:  result = sum;
            OP_SLT:  result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/serial_alu_seq.sv
// +----------------------------------------------------------------------+
// | serial_alu_seq                                                       |
// | Bit-serial WIDTH-bit ALU sequencer driving one serial_alu_slice,     |
// | LSB first. Option macro: SERIAL_ALU_SLT_OVF_FIX_EN (overflow-correct |
// | signed SLT).                                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int              IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctrl_q;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] result_sh;

    logic [1:0]       slice_op;
    logic             slice_res;
    logic             slice_cout;
    logic             last_bit;
    logic [WIDTH-1:0] res_final;
    logic             set_bit;
    logic             ovf_bit;
    logic             less_bit;
    logic [WIDTH-1:0] out_res;
    logic             out_ovf;

    // SLT runs the subtraction through the sum path; the less input stays 0.
    assign slice_op = (ctrl_q[1:0] == OP_SLT) ? OP_SUM : ctrl_q[1:0];

    serial_alu_slice u_slice (
        .in1      (a_q[idx]),
        .in2      (b_q[idx]),
        .carryIn  (carry),
        .ainvert  (ctrl_q[3]),
        .binvert  (ctrl_q[2]),
        .less     (1'b0),
        .op       (slice_op),
        .result   (slice_res),
        .carryOut (slice_cout)
    );

    assign last_bit  = (idx == IDX_LAST);
    assign res_final = {slice_res, result_sh[WIDTH-1:1]};
    assign set_bit   = slice_res;
    assign ovf_bit   = carry ^ slice_cout;

`ifdef SERIAL_ALU_SLT_OVF_FIX_EN
    assign less_bit = set_bit ^ ovf_bit;
`else
    assign less_bit = set_bit;
`endif

    // Final values, meaningful only while the MSB is in the slice.
    always_comb begin
        out_res = '0;
        out_ovf = 1'b0;
        case (ctrl_q)
            ALU_CTRL_AND, ALU_CTRL_OR, ALU_CTRL_NOR: begin
                out_res = res_final;
            end
            ALU_CTRL_ADD, ALU_CTRL_SUB: begin
                out_res = res_final;
                out_ovf = ovf_bit;
            end
            ALU_CTRL_SLT: begin
                out_res = {{(WIDTH-1){1'b0}}, less_bit};
            end
            default: begin
                out_res = '0;
                out_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            result_sh <= '0;
            result    <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_q       <= a;
            b_q       <= b;
            ctrl_q    <= alu_ctrl;
            idx       <= '0;
            carry     <= alu_ctrl[2];
            result_sh <= '0;
        end else if (state == ST_RUN) begin
            result_sh <= res_final;
            carry     <= slice_cout;
            if (last_bit) begin
                idx      <= '0;
                result   <= out_res;
                zero     <= (out_res == '0);
                overflow <= out_ovf;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign ready = (state == ST_IDLE) || (state == ST_DONE);
    assign done  = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_seq.sv
// +----------------------------------------------------------------------+
// | tb_serial_alu_seq                                                    |
// | Directed scoreboard bench for serial_alu_seq at WIDTH=8.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_serial_alu_seq;

    localparam int WIDTH = 8;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_BAD = 4'b0011;

    // Raw MSB-sum SLT is wrong whenever a-b overflows.
`ifdef SERIAL_ALU_SLT_OVF_FIX_EN
    localparam logic [7:0] SLT_80_01 = 8'h01;
    localparam logic [7:0] SLT_7F_80 = 8'h00;
`else
    localparam logic [7:0] SLT_80_01 = 8'h00;
    localparam logic [7:0] SLT_7F_80 = 8'h01;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       alu_ctrl = 4'h0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             o;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with result 0x%0h expected no done", result);
            end else begin
                mon_e = q.pop_front();
                chk("result", 32'(result), 32'(mon_e.res));
                chk("zero", 32'(zero), 32'(mon_e.z));
                chk("overflow", 32'(overflow), 32'(mon_e.o));
            end
        end
    end

    // Call at a negedge where ready is high; returns at the negedge after accept.
    task automatic issue(input logic [3:0] c, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] er, input logic ez, input logic eo,
                         input bit expect_done);
        exp_t e;
        alu_ctrl = c;
        a        = av;
        b        = bv;
        start    = 1'b1;
        if (expect_done) begin
            e.res = er;
            e.z   = ez;
            e.o   = eo;
            q.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        a        = ~av;
        b        = bv ^ 8'h5A;
        alu_ctrl = ~c;
    endtask

    // Waits for done; the count must match exp_cyc and ready must stay low meanwhile.
    task automatic wait_done(input string name, input int exp_cyc);
        int cyc = 0;
        bit busy_bad = 1'b0;
        while (!done && cyc < 40) begin
            if (ready !== 1'b0) busy_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
        chk({name, "_busy"}, 32'(busy_bad), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [3:0] c, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] er, input logic ez,
                          input logic eo);
        issue(c, av, bv, er, ez, eo, 1'b1);
        wait_done(name, WIDTH);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // done lands in the (WIDTH+1)th cycle after the accepting edge.
        run_op("add_7f_01", C_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run_op("add_ff_01", C_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op("sub_80_01", C_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        issue(C_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
        wait_done("sub_05_05", WIDTH);
        issue(C_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b1);
        chk("b2b_no_idle", 32'(ready), 32'd0);
        wait_done("and_b2b", WIDTH);
        @(negedge clk);

        run_op("slt_03_05", C_SLT, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0);
        run_op("slt_80_01", C_SLT, 8'h80, 8'h01, SLT_80_01, SLT_80_01 == 8'h00, 1'b0);
        run_op("slt_05_03", C_SLT, 8'h05, 8'h03, 8'h00, 1'b1, 1'b0);
        run_op("slt_7f_80", C_SLT, 8'h7F, 8'h80, SLT_7F_80, SLT_7F_80 == 8'h00, 1'b0);
        run_op("nor_f0_0f", C_NOR, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0);
        run_op("or_a0_05", C_OR, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0);
        run_op("bad_code", C_BAD, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);

        // A start pulse mid-RUN must not disturb the operation in flight.
        issue(C_ADD, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        alu_ctrl = C_SUB;
        a        = 8'h99;
        b        = 8'h01;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("add_ignore_start", WIDTH - 3);
        repeat (12) @(negedge clk);

        // Abort mid-RUN with reset.
        issue(C_ADD, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        chk("abort_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        run_op("add_after_rst", C_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
